lc3_memory_ctrl: RTL
====================

# lc3_memory_ctrl

Memory and memory-mapped I/O responder for the LC-3 core. Owns MAR and MDR, accepts address/data from the shared DATABUS, and services read/write requests issued by the control FSM (MIO_EN, R_W), returning the ready flag R after a configurable wait. Decodes the keyboard, display and machine-control registers (xFE00–xFFFE) and forwards all other addresses to an external synchronous SRAM port.

## Interface
- WAIT_CYCLES, 2, extra SRAM wait states inserted before the SRAM strobe (0–15)
- KB_PRIORITY, 3'd4, priority presented with the keyboard interrupt request
- KB_VECTOR, 8'h80, interrupt vector presented with the keyboard request
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- DATABUS  in  16  shared bus value
- LD_MAR, LD_MDR  in  1  load enables from control FSM
- MIO_EN  in  1  memory/IO request, held high until R seen
- R_W  in  1  1 = write, 0 = read; sampled when request accepted
- GateMDR  in  1  drive MDR onto bus
- MDRbus_out  inout  16  MDR when GateMDR, else high-Z
- R  out  1  access complete, registered
- mem_addr  out  16  SRAM address (= latched MAR)
- mem_wdata  out  16  SRAM write data (= MDR)
- mem_en, mem_we  out  1  one-cycle SRAM strobe / write qualifier
- mem_rdata  in  16  SRAM read data, valid the cycle after mem_en
- kb_data  in  8; kb_valid  in  1  keyboard character strobe
- disp_data  out  8; disp_valid  out  1; disp_ready  in  1  display handshake
- kb_int_req  out  1; kb_int_pri  out  3; kb_int_vec  out  8  interrupt request
- halt  out  1  MCR[15] cleared

## Operation
- MAR <= DATABUS on LD_MAR. MDR <= DATABUS on LD_MDR when MIO_EN=0; when MIO_EN=1, MDR loads read data only in DONE with LD_MDR=1.
- FSM states: IDLE, WAIT, ISSUE, DONE, HOLD.
- IDLE: MIO_EN=1 → latch R_W and address class; I/O address → DONE; memory → WAIT (counter=WAIT_CYCLES) or ISSUE if WAIT_CYCLES=0.
- WAIT: decrement; at 0 → ISSUE. ISSUE: mem_en=1, mem_we=latched R_W, one cycle → DONE.
- DONE: R=1 one cycle; read data = mem_rdata or I/O register; I/O write side effects commit here → HOLD.
- HOLD: wait for MIO_EN=0 → IDLE. R low. A request held high never re-triggers.
- I/O map: xFE00 KBSR ([15] ready, [14] IE writable), xFE02 KBDR (read clears KBSR[15]), xFE04 DSR ([15] = !disp_valid, read-only), xFE06 DDR (write: disp_data<=MDR[7:0], disp_valid=1 until disp_ready), xFFFE MCR ([15] writable). Other xFExx/xFFxx addresses read x0000, writes ignored, no SRAM access.
- kb_valid: KBDR<=kb_data, KBSR[15]=1; overwrites unread data. kb_valid coincident with KBDR read: new data wins, KBSR[15] stays 1.
- kb_int_req = KBSR[15]&KBSR[14]; pri/vec constant.
- DDR write while disp_valid=1: data replaced, valid stays high.
- halt = !MCR[15].

## Timing
- Reset values: MAR=MDR=0, R=0, mem_en=mem_we=0, disp_valid=0, disp_data=0, KBSR=0, KBDR=0, MCR=x8000, halt=0, FSM=IDLE.
- Memory latency: MIO_EN rises cycle 0 → R high in cycle WAIT_CYCLES+2; I/O: R high in cycle 1.
- mem_addr/mem_wdata stable from ISSUE through DONE.
- reset asserted mid-access aborts; no write side effect after reset edge; mem_en drops immediately.
- MIO_EN dropped before DONE: access completes, R pulses, FSM goes DONE→HOLD→IDLE.

## Structure
- Package lc3_mem_pkg: state enum, I/O address constants (KBSR/KBDR/DSR/DDR/MCR), MCR reset value.
- Sub-module lc3_io_regs: keyboard/display/MCR registers and read mux; controller holds FSM, MAR, MDR.

## Test plan
- WAIT_CYCLES=2, MAR=x3000, SRAM x3000=xBEEF, read → mem_en in cycle 3, R in cycle 4, MDR=xBEEF, gated bus=xBEEF.
- Write MDR=x1234 to x4000 → single mem_en&mem_we with addr x4000, data x1234; readback x1234.
- kb_valid with kb_data=x41, KBSR write x4000 → kb_int_req=1; read KBDR → MDR=x0041, KBSR[15]=0, req drops.
- Write DDR x0058 with disp_ready=0 → DSR reads x0000, disp_data=x58; disp_ready=1 → DSR reads x8000.
- Write MCR x0000 → halt=1 cycle after DONE; R in cycle 1, no mem_en.
- Assert reset during WAIT of a write → mem_en never pulses, R=0, FSM IDLE.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory / memory-mapped I/O controller.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_DONE,
        ST_HOLD
    } mem_state_e;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE06 - 16'h0002;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

    localparam logic [15:0] MCR_RESET = 16'h8000;

    // xFE00-xFFFF is the device page; nothing there ever reaches the SRAM.
    function automatic logic is_io_addr(input logic [15:0] addr);
        return addr[15:9] == 7'h7F;
    endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// Keyboard, display and machine-control registers plus their read mux.
module lc3_io_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [7:0]  kb_data,
    input  logic        kb_valid,
    input  logic        disp_ready,
    output logic [15:0] rdata,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    output logic        kb_int_req,
    output logic        halt
);

    logic       kb_ready_q, kb_ready_d;
    logic       kb_ie_q, kb_ie_d;
    logic [7:0] kbdr_q, kbdr_d;
    logic [7:0] disp_data_q, disp_data_d;
    logic       disp_valid_q, disp_valid_d;
    logic       mcr15_q, mcr15_d;

    always_comb begin
        kb_ready_d   = kb_ready_q;
        kb_ie_d      = kb_ie_q;
        kbdr_d       = kbdr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        mcr15_d      = mcr15_q;

        // A new character arriving in the same cycle as a KBDR read wins.
        if (rd_en && addr == ADDR_KBDR)
            kb_ready_d = 1'b0;
        if (kb_valid) begin
            kbdr_d     = kb_data;
            kb_ready_d = 1'b1;
        end

        if (wr_en && addr == ADDR_KBSR)
            kb_ie_d = wdata[14];

        if (disp_valid_q && disp_ready)
            disp_valid_d = 1'b0;
        if (wr_en && addr == ADDR_DDR) begin
            disp_data_d  = wdata[7:0];
            disp_valid_d = 1'b1;
        end

        if (wr_en && addr == ADDR_MCR)
            mcr15_d = wdata[15];

        case (addr)
            ADDR_KBSR: rdata = {kb_ready_q, kb_ie_q, 14'h0000};
            ADDR_KBDR: rdata = {8'h00, kbdr_q};
            ADDR_DSR:  rdata = {~disp_valid_q, 15'h0000};
            ADDR_MCR:  rdata = {mcr15_q, 15'h0000};
            default:   rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_ready_q   <= 1'b0;
            kb_ie_q      <= 1'b0;
            kbdr_q       <= 8'h00;
            disp_data_q  <= 8'h00;
            disp_valid_q <= 1'b0;
            mcr15_q      <= MCR_RESET[15];
        end else begin
            kb_ready_q   <= kb_ready_d;
            kb_ie_q      <= kb_ie_d;
            kbdr_q       <= kbdr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            mcr15_q      <= mcr15_d;
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign kb_int_req = kb_ready_q & kb_ie_q;
    assign halt       = ~mcr15_q;

endmodule

// File: rtl/lc3_memory_ctrl.sv
// LC-3 memory controller: MAR/MDR, access sequencing with SRAM wait states,
// and dispatch of device-page accesses to lc3_io_regs.
//
// state | meaning
// IDLE  | no access; waits for MIO_EN
// WAIT  | counting SRAM wait states
// ISSUE | mem_en strobe to SRAM
// DONE  | R high, read data valid, I/O writes commit
// HOLD  | waits for MIO_EN to drop
module lc3_memory_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [2:0] KB_PRIORITY = 3'd4,
    parameter logic [7:0] KB_VECTOR   = 8'h80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] DATABUS,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        GateMDR,
    inout  wire  [15:0] MDRbus_out,
    output logic        R,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic [7:0]  kb_data,
    input  logic        kb_valid,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic        kb_int_req,
    output logic [2:0]  kb_int_pri,
    output logic [7:0]  kb_int_vec,
    output logic        halt
);

    // Terminal count is zero, so WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic        io_q, io_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        r_q, r_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;

    logic [15:0] io_rdata;
    logic        io_rd, io_wr;

    assign io_rd = (state_q == ST_DONE) && io_q && !rw_q;
    assign io_wr = (state_q == ST_DONE) && io_q && rw_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        io_d     = io_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        r_d      = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;

        if (LD_MAR)
            mar_d = DATABUS;
        if (LD_MDR && !MIO_EN)
            mdr_d = DATABUS;
        else if (LD_MDR && state_q == ST_DONE)
            mdr_d = io_q ? io_rdata : mem_rdata;

        case (state_q)
            ST_IDLE: begin
                if (MIO_EN) begin
                    rw_d = R_W;
                    io_d = is_io_addr(mar_q);
                    if (is_io_addr(mar_q)) begin
                        state_d = ST_DONE;
                        r_d     = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d  = ST_ISSUE;
                        mem_en_d = 1'b1;
                        mem_we_d = R_W;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_ISSUE;
                    mem_en_d = 1'b1;
                    mem_we_d = rw_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_DONE;
                r_d     = 1'b1;
            end
            ST_DONE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!MIO_EN)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            rw_q     <= 1'b0;
            io_q     <= 1'b0;
            mar_q    <= 16'h0000;
            mdr_q    <= 16'h0000;
            r_q      <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            io_q     <= io_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            r_q      <= r_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
        end
    end

    lc3_io_regs u_io_regs (
        .clk        (clk),
        .reset      (reset),
        .addr       (mar_q),
        .wdata      (mdr_q),
        .rd_en      (io_rd),
        .wr_en      (io_wr),
        .kb_data    (kb_data),
        .kb_valid   (kb_valid),
        .disp_ready (disp_ready),
        .rdata      (io_rdata),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .kb_int_req (kb_int_req),
        .halt       (halt)
    );

    assign MDRbus_out = GateMDR ? mdr_q : 16'hzzzz;
    assign R          = r_q;
    assign mem_addr   = mar_q;
    assign mem_wdata  = mdr_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign kb_int_pri = KB_PRIORITY;
    assign kb_int_vec = KB_VECTOR;

endmodule
